uart_receiver: RTL and testbench

//  Serial-to-parallel stage directly downstream of the UART transmitter; consumes its serial line
//  (idle-high, 1 start bit 0, 8 data bits LSB first, 1 stop bit 1). Recovers each byte and presents it
//  on a 1-entry valid/ready holding register, flagging framing errors and overruns.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 38 +++
 rtl/uart_receiver.sv | 136 +++++++++++++
 tb/tb_uart_receiver.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and line-level constants.
// The transmitter imports the same package so both ends agree on framing.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_STOP    = 3'd3,
        RX_RECOVER = 3'd4
    } rx_state_e;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_START_BIT  = 1'b0;
    localparam logic UART_STOP_BIT   = 1'b1;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Width of a down-counter that must hold values up to cpb-1, never below 1 bit.
    function automatic int cnt_width(input int cpb);
        int w;
        w = $clog2(cpb + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input synchronizer for the serial line. Flops reset to the idle level so a
// reset never looks like a start bit; STAGES=0 is a plain wire.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst};
            assign dout = din;
        end else begin : g_chain
            logic [STAGES-1:0] chain;

            // Shift the line through STAGES flops, oldest sample at the top.
            always_ff @(posedge clk) begin
                if (rst) begin
                    chain <= {STAGES{UART_IDLE_LEVEL}};
                end else begin
                    chain[0] <= din;
                    for (int i = 1; i < STAGES; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end

            assign dout = chain[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8N1 framing, mid-bit sampling, 1-entry valid/ready holding
// register with framing-error flag and overrun pulse.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] rx_data,
    output logic       rx_frame_err,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int CW   = cnt_width(CLKS_PER_BIT);
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((HALF > 0) ? (HALF - 1) : 0);
    localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

    rx_state_e     state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          rxs;
    logic          sample;
    logic          complete;

    uart_rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (serial_in),
        .dout (rxs)
    );

    assign sample   = (cnt == '0);
    assign complete = (state == RX_STOP) && sample;
    assign rx_busy  = (state != RX_IDLE);

    // Frame FSM, bit counters, shift register and holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RX_IDLE;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            rx_data      <= '0;
            rx_frame_err <= 1'b0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;

            // A completing frame either loads (possibly alongside a transfer)
            // or is dropped when the old byte is still unclaimed.
            if (complete) begin
                if (rx_valid && !rx_ready) begin
                    rx_overrun <= 1'b1;
                end else begin
                    rx_data      <= shreg;
                    rx_frame_err <= (rxs != UART_STOP_BIT);
                    rx_valid     <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                RX_IDLE: begin
                    if (rxs == UART_START_BIT) begin
                        if (HALF == 0) begin
                            // Detect cycle doubles as the start-bit sample.
                            state <= RX_DATA;
                            cnt   <= CNT_BIT;
                            idx   <= '0;
                        end else begin
                            state <= RX_START;
                            cnt   <= CNT_HALF;
                        end
                    end
                end
                RX_START: begin
                    if (!sample) begin
                        cnt <= cnt - CW'(1);
                    end else if (rxs == UART_START_BIT) begin
                        state <= RX_DATA;
                        cnt   <= CNT_BIT;
                        idx   <= '0;
                    end else begin
                        state <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (!sample) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        shreg <= {rxs, shreg[7:1]};
                        idx   <= idx + 3'd1;
                        cnt   <= CNT_BIT;
                        if (idx == IDX_LAST) begin
                            state <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (!sample) begin
                        cnt <= cnt - CW'(1);
                    end else if (rxs == UART_STOP_BIT) begin
                        state <= RX_IDLE;
                    end else begin
                        state <= RX_RECOVER;
                    end
                end
                RX_RECOVER: begin
                    // A line held low after a bad stop bit must return high
                    // before another start bit is accepted.
                    if (rxs == UART_IDLE_LEVEL) begin
                        state <= RX_IDLE;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: a fast instance (1 clk/bit, no synchronizer) and a
// slow instance (16 clk/bit, 2-flop synchronizer) driven by behavioural frame
// generators; delivered bytes are scored against an expected queue.
module tb_uart_receiver;

    logic clk = 1'b0;
    logic rst;

    logic       serial_a, rx_ready_a;
    logic [7:0] rx_data_a;
    logic       rx_frame_err_a, rx_valid_a, rx_overrun_a, rx_busy_a;

    logic       serial_b, rx_ready_b;
    logic [7:0] rx_data_b;
    logic       rx_frame_err_b, rx_valid_b, rx_overrun_b, rx_busy_b;

    int total = 0;
    int bad   = 0;
    int ovr_cnt_a = 0;

    // Expected deliveries for instance a: {frame_err, byte}.
    logic [8:0] exp_q[$];

    uart_receiver #(.CLKS_PER_BIT(1), .SYNC_STAGES(0)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_a),
        .rx_data      (rx_data_a),
        .rx_frame_err (rx_frame_err_a),
        .rx_valid     (rx_valid_a),
        .rx_ready     (rx_ready_a),
        .rx_overrun   (rx_overrun_a),
        .rx_busy      (rx_busy_a)
    );

    uart_receiver #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_b),
        .rx_data      (rx_data_b),
        .rx_frame_err (rx_frame_err_b),
        .rx_valid     (rx_valid_b),
        .rx_ready     (rx_ready_b),
        .rx_overrun   (rx_overrun_b),
        .rx_busy      (rx_busy_b)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 8N1 frame on line a, one bit per clock; line left at the stop level.
    task automatic send_a(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            serial_a = frame[k];
            @(posedge clk); #1;
        end
    endtask

    // One 8N1 frame on line b, sixteen clocks per bit.
    task automatic send_b(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            serial_b = frame[k];
            repeat (16) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_a(input int n);
        serial_a = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard for instance a: every transfer must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_overrun_a) ovr_cnt_a++;
            if (rx_valid_a && rx_ready_a) begin
                chk("mon_expected_frame", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("mon_frame", {23'd0, rx_frame_err_a, rx_data_a}, {23'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        logic       stop_ok;
        logic       saw_busy, saw_valid;
        logic [7:0] fixed [4];
        fixed[0] = 8'h00; fixed[1] = 8'hFF; fixed[2] = 8'hA5; fixed[3] = 8'h5A;

        // Reset
        rst = 1'b1; serial_a = 1'b1; serial_b = 1'b1;
        rx_ready_a = 1'b1; rx_ready_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_a",  rx_data_a, 8'h00);
        chk("rst_valid_a", rx_valid_a, 1'b0);
        chk("rst_err_a",   rx_frame_err_a, 1'b0);
        chk("rst_ovr_a",   rx_overrun_a, 1'b0);
        chk("rst_busy_a",  rx_busy_a, 1'b0);
        chk("rst_valid_b", rx_valid_b, 1'b0);
        chk("rst_busy_b",  rx_busy_b, 1'b0);
        rst = 1'b0;
        idle_a(3);

        // Single frame 0x4A: rx_valid rises exactly ten cycles after the start bit.
        exp_q.push_back({1'b0, 8'h4A});
        begin
            logic [9:0] frame;
            frame = {1'b1, 8'h4A, 1'b0};
            for (int k = 0; k < 10; k++) begin
                serial_a = frame[k];
                @(posedge clk); #1;
                if (k == 8) chk("t1_not_early", rx_valid_a, 1'b0);
                if (k == 9) begin
                    chk("t1_valid", rx_valid_a, 1'b1);
                    chk("t1_data",  rx_data_a, 8'h4A);
                    chk("t1_err",   rx_frame_err_a, 1'b0);
                end
            end
        end
        serial_a = 1'b1;
        @(posedge clk); #1;
        chk("t1_one_cycle", rx_valid_a, 1'b0);
        idle_a(3);

        // Back-to-back fixed bytes, no idle between frames.
        foreach (fixed[i]) begin
            exp_q.push_back({1'b0, fixed[i]});
            send_a(fixed[i], 1'b1);
        end
        idle_a(4);
        chk("t2_drained", exp_q.size(), 0);

        // Random bytes, random bad stop bits and random gaps.
        for (int n = 0; n < 16; n++) begin
            b = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 3) != 0);
            exp_q.push_back({~stop_ok, b});
            send_a(b, stop_ok);
            if (!stop_ok) idle_a(1);
            if ($urandom_range(0, 1) == 1) idle_a($urandom_range(1, 3));
        end
        idle_a(4);
        chk("rand_drained", exp_q.size(), 0);

        // Bad stop bit on 0x3C, line held low: one errored frame, nothing else.
        exp_q.push_back({1'b1, 8'h3C});
        send_a(8'h3C, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("t3_busy_low_hold", rx_busy_a, 1'b1);
        idle_a(3);
        chk("t3_idle_after", rx_busy_a, 1'b0);
        chk("t3_no_spurious", rx_valid_a, 1'b0);
        chk("t3_drained", exp_q.size(), 0);

        // Overrun: consumer stalled across two frames; first byte survives.
        rx_ready_a = 1'b0;
        exp_q.push_back({1'b0, 8'h11});
        send_a(8'h11, 1'b1);
        send_a(8'h22, 1'b1);
        serial_a = 1'b1;
        chk("t4_overrun", rx_overrun_a, 1'b1);
        chk("t4_kept",    rx_data_a, 8'h11);
        chk("t4_valid",   rx_valid_a, 1'b1);
        @(posedge clk); #1;
        chk("t4_pulse_one", rx_overrun_a, 1'b0);
        rx_ready_a = 1'b1;
        @(posedge clk); #1;
        chk("t4_accepted", rx_valid_a, 1'b0);
        chk("t4_drained", exp_q.size(), 0);
        idle_a(3);

        // Slow instance: a short low glitch must not produce a frame.
        saw_busy = 1'b0; saw_valid = 1'b0;
        serial_b = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        serial_b = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            saw_busy  |= rx_busy_b;
            saw_valid |= rx_valid_b;
        end
        chk("t5_glitch_seen",  saw_busy, 1'b1);
        chk("t5_glitch_nodata", saw_valid, 1'b0);
        chk("t5_glitch_idle",  rx_busy_b, 1'b0);

        // Slow instance: full frame 0xC3.
        send_b(8'hC3, 1'b1);
        serial_b = 1'b1;
        for (int i = 0; i < 60 && !rx_valid_b; i++) begin
            @(posedge clk); #1;
        end
        chk("t5_valid", rx_valid_b, 1'b1);
        chk("t5_data",  rx_data_b, 8'hC3);
        chk("t5_err",   rx_frame_err_b, 1'b0);
        chk("t5_no_ovr", rx_overrun_b, 1'b0);
        rx_ready_b = 1'b1;
        @(posedge clk); #1;
        rx_ready_b = 1'b0;
        chk("t5_accepted", rx_valid_b, 1'b0);

        // Reset in the middle of a frame, then a clean 0x81.
        begin
            logic [9:0] frame;
            frame = {1'b1, 8'hFF, 1'b0};
            for (int k = 0; k < 5; k++) begin
                serial_a = frame[k];
                @(posedge clk); #1;
            end
        end
        rst = 1'b1; serial_a = 1'b1;
        @(posedge clk); #1;
        chk("t6_rst_data",  rx_data_a, 8'h00);
        chk("t6_rst_valid", rx_valid_a, 1'b0);
        chk("t6_rst_err",   rx_frame_err_a, 1'b0);
        chk("t6_rst_busy",  rx_busy_a, 1'b0);
        chk("t6_rst_ovr",   rx_overrun_a, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_a(2);
        exp_q.push_back({1'b0, 8'h81});
        send_a(8'h81, 1'b1);
        idle_a(5);

        // Final report
        chk("end_queue_empty", exp_q.size(), 0);
        chk("end_overrun_count", ovr_cnt_a, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
